pt8211_src_sched: RTL and testbench
===================================

Name: pt8211_src_sched

Overview:
- Sequences the PT8211 DAC sample path and shares it between two stereo sample sources: source 0 (ROM tone generator) and source 1 (streaming FIFO).
- Sits between the sources and the pt8211 driver; answers every driver word request with one scaled 16-bit word.
- Switches source and mutes only at stereo-frame boundaries, using a linear gain ramp so there are no clicks.
- Counts underruns.

Parameters:
- DW, 16, sample word width (signed two's complement).
- GW, 4, gain resolution bits; full gain = 2**GW; a full fade takes 2**GW frames.
- UCW, 16, underrun counter width.

Ports:
- clk  in  1  bit clock; same net as the driver's clk_1p536m.
- rst_n  in  1  asynchronous active-low reset.
- dac_req  in  1  one-cycle pulse from the driver per 16-bit word; words alternate left, right, with left first after reset.
- dac_data  out  DW  word to the driver; registered.
- s0_valid  in  1  source 0 has a word.
- s0_data  in  DW  source 0 word.
- s0_ready  out  1  source 0 pop strobe; a word transfers when s0_valid and s0_ready are both high.
- s1_valid  in  1  source 1 has a word.
- s1_data  in  DW  source 1 word.
- s1_ready  out  1  source 1 pop strobe.
- cfg_sel  in  1  requested source.
- cfg_mute  in  1  request mute.
- active_src  out  1  source currently routed.
- busy  out  1  high in FADE_OUT, SWITCH and FADE_IN.
- underrun  out  1  one-cycle pulse on an underrun.
- underrun_cnt  out  UCW  saturating underrun count.

Behaviour:
- Reset values:
  - dac_data=0, active_src=0, gain=0, state=SWITCH, lr=LEFT.
  - underrun=0, underrun_cnt=0, both ready=0.
  - First frame after reset is zeros; the block then fades in source cfg_sel.
- Word phase: lr toggles on every dac_req. A dac_req with lr=RIGHT is the frame end (FE).
- Pop rule:
  - sX_ready = dac_req & (active_src==X) & (state is PLAY, FADE_OUT or FADE_IN). This is combinational, the only combinational output.
  - The inactive source is never popped.
- Data path:
  - dac_data updates in the cycle after dac_req (1-cycle latency) and holds until the next dac_req.
  - dac_data = (sample*gain) >>> GW, signed multiply with full-width intermediate. Result is exact when gain=2**GW.
  - In SWITCH or MUTED, dac_data = 0.
- Underrun:
  - Condition: a pop-eligible dac_req while the active source's valid=0.
  - Outputs dac_data=0 for that word and pulses underrun for one cycle.
  - underrun_cnt increments and saturates at all-ones.
  - lr still toggles, so channel alignment is kept.
- States:
  - gain changes only at FE, in steps of ±1, and applies to both words of the next frame.
  - cfg_sel and cfg_mute are sampled only at FE. A change mid-frame takes effect at the next FE.
- Transitions, all evaluated at FE:
  - PLAY (gain=full): if cfg_mute, or cfg_sel!=active_src, go to FADE_OUT.
  - FADE_OUT: gain--. When gain reaches 0, go to MUTED if cfg_mute, else SWITCH.
  - SWITCH: active_src<=cfg_sel on entry. Lasts exactly one frame of zeros, then goes to FADE_IN.
  - FADE_IN: gain++. When gain reaches full, go to PLAY. If cfg_mute or cfg_sel!=active_src, go to FADE_OUT, descending from the current gain.
  - MUTED: gain=0. When !cfg_mute, go to SWITCH.
- Simultaneous events:
  - An underrun at FE still advances the state and gain.
  - cfg toggled and restored within one frame is never seen.
- rst_n asserted mid-frame: everything returns to the reset values at once. There is no partial pop, and the driver sees dac_data=0 on its next latch.

Optional Feature:
- Macro: PT8211_UNDERRUN_HOLD_EN.
- Defined:
  - On underrun, dac_data repeats the last word output on the same channel. This needs per-channel last-word registers, reset to 0.
  - The hold value is scaled by the current gain.
- Undefined: an underrun outputs 0 and no last-word registers exist.
- Counter and pulse behaviour are identical in both builds.

Decomposition:
- Package pt8211_pkg holds:
  - state enum: PLAY, FADE_OUT, SWITCH, FADE_IN, MUTED.
  - LR_LEFT/LR_RIGHT constants.
  - GAIN_FULL = 2**GW.
- One sub-module, pt8211_gain_mul: combinational signed DW x (GW+1) multiply and arithmetic shift, instantiated once. The output register stays in pt8211_src_sched.

Test Plan:
- After reset, cfg_sel=0, s0 always valid with constant 16'h4000: frame 1 is 0/0. Then 16 fade-in frames with left word = 16'h4000*g>>4, i.e. 16'h0400 at g=1. Then steady 16'h4000 with state PLAY.
- In PLAY on src0, set cfg_sel=1 mid-frame: fade starts at the next FE, 16 frames down, one zero frame, active_src=1, 16 frames up on s1. s0_ready never asserts after the switch; busy is high throughout.
- Set cfg_mute=1 during FADE_IN at g=5: descent goes 5→0 over 5 frames, then MUTED with zeros and no pops. Clearing mute gives one SWITCH frame, then fade-in.
- In PLAY, drop s0_valid for 3 words: 3 underrun pulses, underrun_cnt=3, and those words are 0 (or the held word with PT8211_UNDERRUN_HOLD_EN). L/R alignment is preserved.
- Preload underrun_cnt near max (UCW=4 build) and force 20 underruns: count saturates at 15.
- Assert rst_n low mid-frame during FADE_OUT: all outputs return to reset values immediately, and the next frame is zeros with lr=LEFT.

Source files
------------

// File: rtl/pt8211_pkg.sv
// Shared types and constants for the PT8211 source scheduler.
package pt8211_pkg;

  typedef enum logic [2:0] {
    PLAY     = 3'd0,
    FADE_OUT = 3'd1,
    SWITCH   = 3'd2,
    FADE_IN  = 3'd3,
    MUTED    = 3'd4
  } state_t;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  localparam int GW_DEFAULT = 4;
  localparam int GAIN_FULL  = 2 ** GW_DEFAULT;

  function automatic int gain_full(input int gw);
    return 2 ** gw;
  endfunction

endpackage

// File: rtl/pt8211_gain_mul.sv
// Signed sample times unsigned gain, arithmetically shifted back to sample width.
module pt8211_gain_mul #(
  parameter int DW = 16,
  parameter int GW = 4
) (
  input  logic signed [DW-1:0] sample,
  input  logic        [GW:0]   gain,
  output logic signed [DW-1:0] scaled
);

  logic signed [DW+GW+1:0] prod;

  // Zero-extend the gain so the multiply stays signed with full-width intermediate.
  assign prod   = sample * $signed({1'b0, gain});
  assign scaled = DW'(prod >>> GW);

endmodule

// File: rtl/pt8211_src_sched.sv
// Shares the PT8211 word stream between two stereo sources with click-free gain ramps.
// Optional build macro PT8211_UNDERRUN_HOLD_EN: an underrun repeats the last word of that channel.
module pt8211_src_sched
  import pt8211_pkg::*;
#(
  parameter int DW  = 16,
  parameter int GW  = 4,
  parameter int UCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           dac_req,
  output logic [DW-1:0]  dac_data,
  input  logic           s0_valid,
  input  logic [DW-1:0]  s0_data,
  output logic           s0_ready,
  input  logic           s1_valid,
  input  logic [DW-1:0]  s1_data,
  output logic           s1_ready,
  input  logic           cfg_sel,
  input  logic           cfg_mute,
  output logic           active_src,
  output logic           busy,
  output logic           underrun,
  output logic [UCW-1:0] underrun_cnt
);

  localparam logic [GW:0] G_ONE  = {{GW{1'b0}}, 1'b1};
  localparam logic [GW:0] G_FULL = {1'b1, {GW{1'b0}}};
  localparam logic [GW:0] G_LAST = G_FULL - G_ONE;

  state_t        state;
  logic [GW:0]   gain;
  logic          lr;
  logic          pop_elig;
  logic          act_valid;
  logic [DW-1:0] act_data;
  logic [DW-1:0] mul_in;
  logic [DW-1:0] scaled;
  logic          take_scaled;
  logic          frame_end;
  logic          want_out;

  assign pop_elig  = dac_req & (state inside {PLAY, FADE_OUT, FADE_IN});
  assign s0_ready  = pop_elig & ~active_src;
  assign s1_ready  = pop_elig & active_src;
  assign act_valid = active_src ? s1_valid : s0_valid;
  assign act_data  = active_src ? s1_data : s0_data;
  assign frame_end = dac_req & (lr == LR_RIGHT);
  assign want_out  = cfg_mute | (cfg_sel != active_src);

`ifdef PT8211_UNDERRUN_HOLD_EN
  logic [DW-1:0] hold_left;
  logic [DW-1:0] hold_right;

  assign mul_in      = act_valid ? act_data : ((lr == LR_RIGHT) ? hold_right : hold_left);
  assign take_scaled = pop_elig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_left  <= '0;
      hold_right <= '0;
    end else if (pop_elig && act_valid) begin
      if (lr == LR_RIGHT) hold_right <= act_data;
      else                hold_left  <= act_data;
    end
  end
`else
  assign mul_in      = act_data;
  assign take_scaled = pop_elig & act_valid;
`endif

  pt8211_gain_mul #(.DW(DW), .GW(GW)) u_mul (
    .sample (mul_in),
    .gain   (gain),
    .scaled (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data     <= '0;
      active_src   <= 1'b0;
      gain         <= '0;
      state        <= SWITCH;
      busy         <= 1'b1;
      lr           <= LR_LEFT;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (dac_req) begin
        lr       <= ~lr;
        dac_data <= take_scaled ? scaled : '0;
        if (pop_elig && !act_valid) begin
          underrun <= 1'b1;
          if (underrun_cnt != {UCW{1'b1}}) underrun_cnt <= underrun_cnt + UCW'(1);
        end
      end
      // Gain, source and state move only at the end of a stereo frame.
      if (frame_end) begin
        case (state)
          PLAY: begin
            if (want_out) begin
              state <= FADE_OUT;
              busy  <= 1'b1;
            end
          end
          FADE_OUT: begin
            if (gain <= G_ONE) begin
              gain <= '0;
              if (cfg_mute) begin
                state <= MUTED;
                busy  <= 1'b0;
              end else begin
                state      <= SWITCH;
                busy       <= 1'b1;
                active_src <= cfg_sel;
              end
            end else begin
              gain <= gain - G_ONE;
            end
          end
          SWITCH: begin
            state      <= FADE_IN;
            busy       <= 1'b1;
            gain       <= G_ONE;
            active_src <= cfg_sel;
          end
          FADE_IN: begin
            if (want_out) begin
              state <= FADE_OUT;
              busy  <= 1'b1;
            end else begin
              gain <= gain + G_ONE;
              if (gain == G_LAST) begin
                state <= PLAY;
                busy  <= 1'b0;
              end
            end
          end
          MUTED: begin
            gain <= '0;
            if (!cfg_mute) begin
              state      <= SWITCH;
              busy       <= 1'b1;
              active_src <= cfg_sel;
            end
          end
          default: begin
            state <= SWITCH;
            busy  <= 1'b1;
            gain  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pt8211_src_sched.sv
// Directed, table-driven bench for pt8211_src_sched plus a UCW=4 instance for saturation.
module tb_pt8211_src_sched;

`ifdef PT8211_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dac_req;
  logic        s0_valid, s1_valid;
  logic [15:0] s0_data, s1_data;
  logic        cfg_sel, cfg_mute;

  logic [15:0] dac_data, dac_data4;
  logic        s0_ready, s1_ready, s0_ready4, s1_ready4;
  logic        active_src, active_src4, busy, busy4, underrun, underrun4;
  logic [15:0] underrun_cnt;
  logic [3:0]  underrun_cnt4;

  always #5 clk = ~clk;

  pt8211_src_sched #(.DW(16), .GW(4), .UCW(16)) dut (
    .clk(clk), .rst_n(rst_n), .dac_req(dac_req), .dac_data(dac_data),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .cfg_sel(cfg_sel), .cfg_mute(cfg_mute), .active_src(active_src),
    .busy(busy), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  pt8211_src_sched #(.DW(16), .GW(4), .UCW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dac_req(dac_req), .dac_data(dac_data4),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready4),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready4),
    .cfg_sel(cfg_sel), .cfg_mute(cfg_mute), .active_src(active_src4),
    .busy(busy4), .underrun(underrun4), .underrun_cnt(underrun_cnt4)
  );

  typedef struct {
    logic        s0v;
    logic [15:0] s0d;
    logic        sel;
    logic        mute;
    logic [15:0] exp_d;
    logic        r0;
    logic        r1;
    logic        ur;
    logic        src;
    logic        busy;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s word=%0d got=%0h want=%0h", nm, idx, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic s0v, input logic [15:0] s0d, input logic sel, input logic mute,
                              input logic [15:0] e, input logic r0, input logic r1, input logic ur,
                              input logic src, input logic bsy);
    vec_t v;
    v.s0v = s0v; v.s0d = s0d; v.sel = sel; v.mute = mute; v.exp_d = e;
    v.r0 = r0; v.r1 = r1; v.ur = ur; v.src = src; v.busy = bsy;
    return v;
  endfunction

  // One stereo frame of valid 16'h4000 on s0; cfg may differ between left and right words.
  task automatic frame(input logic sl, input logic ml, input logic sr, input logic mr,
                       input logic [15:0] e, input logic r0, input logic r1, input logic src, input logic bsy);
    vq.push_back(mk(1'b1, 16'h4000, sl, ml, e, r0, r1, 1'b0, src, bsy));
    vq.push_back(mk(1'b1, 16'h4000, sr, mr, e, r0, r1, 1'b0, src, bsy));
  endtask

  task automatic do_word(input vec_t v, input int idx);
    @(negedge clk);
    s0_valid = v.s0v;
    s0_data  = v.s0d;
    cfg_sel  = v.sel;
    cfg_mute = v.mute;
    dac_req  = 1'b1;
    #1;
    chk("s0_ready", idx, 32'(s0_ready), 32'(v.r0));
    chk("s1_ready", idx, 32'(s1_ready), 32'(v.r1));
    chk("active_src", idx, 32'(active_src), 32'(v.src));
    chk("busy", idx, 32'(busy), 32'(v.busy));
    @(negedge clk);
    dac_req = 1'b0;
    chk("dac_data", idx, 32'(dac_data), 32'(v.exp_d));
    chk("dac_data4", idx, 32'(dac_data4), 32'(v.exp_d));
    chk("underrun", idx, 32'(underrun), 32'(v.ur));
    @(negedge clk);
    chk("underrun_clr", idx, 32'(underrun), 32'(0));
    chk("dac_hold", idx, 32'(dac_data), 32'(v.exp_d));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [15:0] cnt_exp;
    logic [3:0]  cnt4_exp;

    rst_n = 1'b0; dac_req = 1'b0;
    s0_valid = 1'b1; s0_data = 16'h4000;
    s1_valid = 1'b1; s1_data = 16'h2000;
    cfg_sel = 1'b0; cfg_mute = 1'b0;

    // Startup: zero frame then fade-in of source 0.
    frame(0, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    for (int g = 1; g <= 15; g++) frame(0, 0, 0, 0, 16'(g * 16'h0400), 1, 0, 0, 1);
    frame(0, 0, 0, 0, 16'h4000, 1, 0, 0, 0);
    frame(0, 0, 0, 0, 16'h4000, 1, 0, 0, 0);
    // cfg glitch inside one frame is never seen; then a real switch request on the right word.
    frame(1, 0, 0, 0, 16'h4000, 1, 0, 0, 0);
    frame(0, 0, 1, 0, 16'h4000, 1, 0, 0, 0);
    for (int g = 16; g >= 1; g--) frame(1, 0, 1, 0, 16'(g * 16'h0400), 1, 0, 0, 1);
    frame(1, 0, 1, 0, 16'h0000, 0, 0, 1, 1);
    for (int g = 1; g <= 15; g++) frame(1, 0, 1, 0, 16'(g * 16'h0200), 0, 1, 1, 1);
    frame(1, 0, 0, 0, 16'h2000, 0, 1, 1, 0);
    for (int g = 16; g >= 1; g--) frame(0, 0, 0, 0, 16'(g * 16'h0200), 0, 1, 1, 1);
    frame(0, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    // Mute arrives during fade-in at g=5.
    for (int g = 1; g <= 4; g++) frame(0, 0, 0, 0, 16'(g * 16'h0400), 1, 0, 0, 1);
    frame(0, 0, 0, 1, 16'h1400, 1, 0, 0, 1);
    for (int g = 5; g >= 1; g--) frame(0, 1, 0, 1, 16'(g * 16'h0400), 1, 0, 0, 1);
    frame(0, 1, 0, 1, 16'h0000, 0, 0, 0, 0);
    frame(0, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    for (int g = 1; g <= 15; g++) frame(0, 0, 0, 0, 16'(g * 16'h0400), 1, 0, 0, 1);
    frame(0, 0, 0, 0, 16'h4000, 1, 0, 0, 0);
    // Three underruns L, R, L between distinct valid words.
    vq.push_back(mk(1, 16'h1234, 0, 0, 16'h1234, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 16'h0567, 0, 0, 16'h0567, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 16'h7777, 0, 0, HOLD ? 16'h1234 : 16'h0000, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 16'h7777, 0, 0, HOLD ? 16'h0567 : 16'h0000, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 16'h7777, 0, 0, HOLD ? 16'h1234 : 16'h0000, 1, 0, 1, 0, 0));
    vq.push_back(mk(1, 16'h0567, 0, 0, 16'h0567, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 16'h1234, 0, 0, 16'h1234, 1, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    dac_req = 1'b1;
    #1;
    chk("rst_dac_data", -1, 32'(dac_data), 32'(0));
    chk("rst_active_src", -1, 32'(active_src), 32'(0));
    chk("rst_busy", -1, 32'(busy), 32'(1));
    chk("rst_underrun", -1, 32'(underrun), 32'(0));
    chk("rst_underrun_cnt", -1, 32'(underrun_cnt), 32'(0));
    chk("rst_s0_ready", -1, 32'(s0_ready), 32'(0));
    chk("rst_s1_ready", -1, 32'(s1_ready), 32'(0));
    @(negedge clk);
    dac_req = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) do_word(vq[i], i);

    chk("underrun_cnt_3", -2, 32'(underrun_cnt), 32'(3));
    chk("underrun_cnt4_3", -2, 32'(underrun_cnt4), 32'(3));

    // 17 more underruns: the UCW=4 instance must stick at 15.
    cnt_exp = 16'd3;
    cnt4_exp = 4'd3;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s0_valid = 1'b0;
      dac_req = 1'b1;
      @(negedge clk);
      dac_req = 1'b0;
      cnt_exp = cnt_exp + 16'd1;
      if (cnt4_exp != 4'hF) cnt4_exp = cnt4_exp + 4'd1;
      chk("sat_underrun", 1000 + i, 32'(underrun), 32'(1));
      chk("sat_cnt", 1000 + i, 32'(underrun_cnt), 32'(cnt_exp));
      chk("sat_cnt4", 1000 + i, 32'(underrun_cnt4), 32'(cnt4_exp));
    end
    chk("underrun_cnt_20", -3, 32'(underrun_cnt), 32'(20));
    chk("underrun_cnt4_15", -3, 32'(underrun_cnt4), 32'(15));

    // Reset in the middle of a fade-out frame.
    do_word(mk(1, 16'h4000, 0, 0, 16'h4000, 1, 0, 0, 0, 0), 2000);
    do_word(mk(1, 16'h4000, 1, 0, 16'h4000, 1, 0, 0, 0, 0), 2001);
    do_word(mk(1, 16'h4000, 1, 0, 16'h4000, 1, 0, 0, 0, 1), 2002);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dac_data", 2003, 32'(dac_data), 32'(0));
    chk("mid_rst_active_src", 2003, 32'(active_src), 32'(0));
    chk("mid_rst_busy", 2003, 32'(busy), 32'(1));
    chk("mid_rst_cnt", 2003, 32'(underrun_cnt), 32'(0));
    chk("mid_rst_cnt4", 2003, 32'(underrun_cnt4), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(1, 16'h4000, 1, 0, 16'h0000, 0, 0, 0, 0, 1);
    do_word(v, 2004);
    do_word(v, 2005);
    do_word(mk(1, 16'h4000, 1, 0, 16'h0200, 0, 1, 0, 1, 1), 2006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
